// File: rtl/ram_port_arbiter_if.sv
// ram_port_arbiter_if
//   Bundles the two requester ports and the RAM-side signals of
//   ram_port_arbiter.
//   slave  : the arbiter's view (takes requests and RAM q, drives grants,
//            read returns and the RAM address/data/write-enable).
//   master : the surrounding view (requesters plus the RAM instance).
//   Per requester x in {A,B}:
//     REQ_x_I, LOCK_x_I, WE_x_I, ADDR_x_I, WDATA_x_I  -> arbiter
//     GNT_x_O, RVALID_x_O, RDATA_x_O                  <- arbiter
//   RAM side: RAM_ADDR_O, RAM_WDATA_O, RAM_WREN_O <- arbiter,
//             RAM_RDATA_I -> arbiter
interface ram_port_arbiter_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 8
);
    logic              REQ_A_I;
    logic              LOCK_A_I;
    logic              WE_A_I;
    logic [ADDR_W-1:0] ADDR_A_I;
    logic [DATA_W-1:0] WDATA_A_I;
    logic              GNT_A_O;
    logic              RVALID_A_O;
    logic [DATA_W-1:0] RDATA_A_O;

    logic              REQ_B_I;
    logic              LOCK_B_I;
    logic              WE_B_I;
    logic [ADDR_W-1:0] ADDR_B_I;
    logic [DATA_W-1:0] WDATA_B_I;
    logic              GNT_B_O;
    logic              RVALID_B_O;
    logic [DATA_W-1:0] RDATA_B_O;

    logic [ADDR_W-1:0] RAM_ADDR_O;
    logic [DATA_W-1:0] RAM_WDATA_O;
    logic              RAM_WREN_O;
    logic [DATA_W-1:0] RAM_RDATA_I;

    modport slave (
        input  REQ_A_I, LOCK_A_I, WE_A_I, ADDR_A_I, WDATA_A_I,
        output GNT_A_O, RVALID_A_O, RDATA_A_O,
        input  REQ_B_I, LOCK_B_I, WE_B_I, ADDR_B_I, WDATA_B_I,
        output GNT_B_O, RVALID_B_O, RDATA_B_O,
        output RAM_ADDR_O, RAM_WDATA_O, RAM_WREN_O,
        input  RAM_RDATA_I
    );

    modport master (
        output REQ_A_I, LOCK_A_I, WE_A_I, ADDR_A_I, WDATA_A_I,
        input  GNT_A_O, RVALID_A_O, RDATA_A_O,
        output REQ_B_I, LOCK_B_I, WE_B_I, ADDR_B_I, WDATA_B_I,
        input  GNT_B_O, RVALID_B_O, RDATA_B_O,
        input  RAM_ADDR_O, RAM_WDATA_O, RAM_WREN_O,
        output RAM_RDATA_I
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
//   Shares one single-port RAM (registered address/data/wren, unregistered q,
//   one-cycle read latency) between requesters A and B. Round-robin
//   arbitration; a requester holding LOCK_x_I keeps the grant for a burst,
//   and a burst counts as a single turn.
// Ports:
//   CLOCK_50_I  system clock, rising edge
//   RESETN_I    asynchronous active-low reset
//   bus         ram_port_arbiter_if.slave: requester A/B handshakes and the
//               RAM address/data/write-enable/q signals
module ram_port_arbiter #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 8
) (
    input  logic              CLOCK_50_I,
    input  logic              RESETN_I,
    ram_port_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_A    = 2'd1,
        OWN_B    = 2'd2
    } owner_t;

    owner_t owner_q, owner_d;
    logic   prio_q,  prio_d;    // 0: A favoured, 1: B favoured
    logic   rsel_q,  rsel_d;    // 0: read in flight belongs to A, 1: to B
    logic   rpend_q, rpend_d;   // read in flight

    logic              gnt_a;
    logic              gnt_b;
    logic              xfer;
    logic              win_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_wren;
    logic              rvalid_a;
    logic              rvalid_b;

    // Grant. Held low during reset so nothing reaches the RAM while the
    // registered state is being cleared.
    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        if (RESETN_I) begin
            case (owner_q)
                OWN_A: gnt_a = bus.REQ_A_I;
                OWN_B: gnt_b = bus.REQ_B_I;
                default: begin
                    if (bus.REQ_A_I && bus.REQ_B_I) begin
                        gnt_a = ~prio_q;
                        gnt_b =  prio_q;
                    end else begin
                        gnt_a = bus.REQ_A_I;
                        gnt_b = bus.REQ_B_I;
                    end
                end
            endcase
        end
    end

    assign xfer = gnt_a | gnt_b;

    // RAM drive: winner's fields, all zero when nobody is granted.
    always_comb begin
        ram_addr  = '0;
        ram_wdata = '0;
        win_we    = 1'b0;
        if (gnt_a) begin
            ram_addr  = bus.ADDR_A_I;
            ram_wdata = bus.WDATA_A_I;
            win_we    = bus.WE_A_I;
        end else if (gnt_b) begin
            ram_addr  = bus.ADDR_B_I;
            ram_wdata = bus.WDATA_B_I;
            win_we    = bus.WE_B_I;
        end
        ram_wren = win_we & xfer;
    end

    // Next state: lock ownership, priority pointer, read tracking.
    always_comb begin
        owner_d = owner_q;
        prio_d  = prio_q;
        rsel_d  = rsel_q;
        rpend_d = xfer & ~win_we;
        if (rpend_d) begin
            rsel_d = gnt_b;
        end

        case (owner_q)
            OWN_NONE: begin
                if (gnt_a && bus.LOCK_A_I) begin
                    owner_d = OWN_A;
                end else if (gnt_b && bus.LOCK_B_I) begin
                    owner_d = OWN_B;
                end
            end
            // Dropping LOCK releases ownership whether this edge is the last
            // beat of the burst or the owner has simply gone idle.
            OWN_A: if (!bus.LOCK_A_I) owner_d = OWN_NONE;
            OWN_B: if (!bus.LOCK_B_I) owner_d = OWN_NONE;
            default: owner_d = OWN_NONE;
        endcase

        // Only a transfer that ends unlocked closes a turn, so a whole burst
        // moves the pointer once.
        if (xfer && (owner_d == OWN_NONE)) begin
            prio_d = gnt_a;
        end
    end

    always_ff @(posedge CLOCK_50_I or negedge RESETN_I) begin
        if (!RESETN_I) begin
            owner_q <= OWN_NONE;
            prio_q  <= 1'b0;
            rsel_q  <= 1'b0;
            rpend_q <= 1'b0;
        end else begin
            owner_q <= owner_d;
            prio_q  <= prio_d;
            rsel_q  <= rsel_d;
            rpend_q <= rpend_d;
        end
    end

    assign rvalid_a = rpend_q & ~rsel_q;
    assign rvalid_b = rpend_q &  rsel_q;

    assign bus.GNT_A_O     = gnt_a;
    assign bus.GNT_B_O     = gnt_b;
    assign bus.RVALID_A_O  = rvalid_a;
    assign bus.RVALID_B_O  = rvalid_b;
    assign bus.RDATA_A_O   = rvalid_a ? bus.RAM_RDATA_I : '0;
    assign bus.RDATA_B_O   = rvalid_b ? bus.RAM_RDATA_I : '0;
    assign bus.RAM_ADDR_O  = ram_addr;
    assign bus.RAM_WDATA_O = ram_wdata;
    assign bus.RAM_WREN_O  = ram_wren;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter
//   Drives ram_port_arbiter through a table of directed cycles, a mid-burst
//   reset sequence and a randomized phase checked against a reference model.
//   A small RAM model (registered address/wren, unregistered q) sits on the
//   RAM side of the interface.
module tb_ram_port_arbiter;
    localparam int AW = 9;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #10 clk = ~clk;

    ram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    ram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .CLOCK_50_I (clk),
        .RESETN_I   (rst_n),
        .bus        (bus)
    );

    // RAM model
    logic [DW-1:0] ram_mem [512];
    logic [AW-1:0] ram_addr_q;
    always @(posedge clk) begin
        if (bus.RAM_WREN_O) ram_mem[bus.RAM_ADDR_O] <= bus.RAM_WDATA_O;
        ram_addr_q <= bus.RAM_ADDR_O;
    end
    assign bus.RAM_RDATA_I = ram_mem[ram_addr_q];

    typedef struct {
        logic          r;
        logic          l;
        logic          w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } req_t;

    typedef struct {
        req_t          ra;
        req_t          rb;
        logic          ga;
        logic          gb;
        logic          wren;
        logic [AW-1:0] addr;
        logic          rva;
        logic          rvb;
        logic [DW-1:0] rdata;
    } vec_t;

    typedef struct {
        int            side;
        logic [DW-1:0] d;
    } rd_t;

    int total = 0;
    int bad   = 0;

    function automatic req_t rq(logic r, logic l, logic w, logic [AW-1:0] a, logic [DW-1:0] d);
        req_t x;
        x.r = r; x.l = l; x.w = w; x.a = a; x.d = d;
        return x;
    endfunction

    function automatic req_t wr_op(logic [AW-1:0] a, logic [DW-1:0] d, logic l);
        return rq(1'b1, l, 1'b1, a, d);
    endfunction

    function automatic req_t rd_op(logic [AW-1:0] a, logic l);
        return rq(1'b1, l, 1'b0, a, '0);
    endfunction

    function automatic req_t idle_op();
        return rq(1'b0, 1'b0, 1'b0, '0, '0);
    endfunction

    function automatic vec_t mk(req_t a, req_t b, logic ga, logic gb, logic wren,
                                logic [AW-1:0] addr, logic rva, logic rvb, logic [DW-1:0] rdata);
        vec_t v;
        v.ra = a; v.rb = b; v.ga = ga; v.gb = gb; v.wren = wren;
        v.addr = addr; v.rva = rva; v.rvb = rvb; v.rdata = rdata;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic drive(input req_t a, input req_t b);
        bus.REQ_A_I = a.r; bus.LOCK_A_I = a.l; bus.WE_A_I = a.w;
        bus.ADDR_A_I = a.a; bus.WDATA_A_I = a.d;
        bus.REQ_B_I = b.r; bus.LOCK_B_I = b.l; bus.WE_B_I = b.w;
        bus.ADDR_B_I = b.a; bus.WDATA_B_I = b.d;
    endtask

    task automatic check_out(input string tag, input logic ga, input logic gb, input logic wren,
                             input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                             input logic rva, input logic rvb, input logic [DW-1:0] rdata);
        chk({tag, ".gnt_a"},  32'(bus.GNT_A_O),     32'(ga));
        chk({tag, ".gnt_b"},  32'(bus.GNT_B_O),     32'(gb));
        chk({tag, ".wren"},   32'(bus.RAM_WREN_O),  32'(wren));
        chk({tag, ".addr"},   32'(bus.RAM_ADDR_O),  32'(addr));
        chk({tag, ".wdata"},  32'(bus.RAM_WDATA_O), 32'(wdata));
        chk({tag, ".rv_a"},   32'(bus.RVALID_A_O),  32'(rva));
        chk({tag, ".rv_b"},   32'(bus.RVALID_B_O),  32'(rvb));
        chk({tag, ".rdat_a"}, 32'(bus.RDATA_A_O),   32'(rva ? rdata : 8'h00));
        chk({tag, ".rdat_b"}, 32'(bus.RDATA_B_O),   32'(rvb ? rdata : 8'h00));
    endtask

    // One table row = one clock cycle: drive after the edge, check at negedge.
    task automatic apply_row(input string tag, input vec_t v);
        logic [DW-1:0] ewd;
        ewd = v.ga ? v.ra.d : (v.gb ? v.rb.d : 8'h00);
        drive(v.ra, v.rb);
        @(negedge clk);
        check_out(tag, v.ga, v.gb, v.wren, v.addr, ewd, v.rva, v.rvb, v.rdata);
        @(posedge clk);
        #1;
    endtask

    // Reference model state for the random phase
    int            m_owner;   // 0 none, 1 A, 2 B
    logic          m_prio;
    logic [DW-1:0] shadow [8];
    rd_t           rdq [$];

    function automatic int pick(req_t a, req_t b);
        if (m_owner == 1) return a.r ? 1 : 0;
        if (m_owner == 2) return b.r ? 2 : 0;
        if (a.r && b.r)   return m_prio ? 2 : 1;
        if (a.r)          return 1;
        if (b.r)          return 2;
        return 0;
    endfunction

    function automatic req_t new_op();
        req_t x;
        x = idle_op();
        if ($urandom_range(9) < 6) begin
            x.r = 1'b1;
            x.w = 1'($urandom_range(1));
            x.a = 9'h180 + 9'($urandom_range(7));
            x.d = 8'($urandom);
            x.l = ($urandom_range(3) == 0);
        end
        return x;
    endfunction

    vec_t tbl [$];
    vec_t post [$];

    initial begin
        req_t I;
        I = idle_op();
        for (int i = 0; i < 512; i++) ram_mem[i] = '0;

        // Reset state with requests present
        rst_n = 1'b0;
        drive(wr_op(9'h010, 8'hA5, 1'b0), rd_op(9'h021, 1'b0));
        #5;
        check_out("reset", 0, 0, 0, '0, '0, 0, 0, '0);
        drive(I, I);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        tbl.push_back(mk(I, I, 0,0,0, 9'h000, 0,0, 8'h00));
        tbl.push_back(mk(I, wr_op(9'h021, 8'h5A, 0), 0,1,1, 9'h021, 0,0, 8'h00));
        tbl.push_back(mk(wr_op(9'h010, 8'hA5, 0), I, 1,0,1, 9'h010, 0,0, 8'h00));
        tbl.push_back(mk(rd_op(9'h010, 0), I, 1,0,0, 9'h010, 0,0, 8'h00));
        tbl.push_back(mk(I, I, 0,0,0, 9'h000, 1,0, 8'hA5));
        tbl.push_back(mk(I, I, 0,0,0, 9'h000, 0,0, 8'h00));
        tbl.push_back(mk(I, wr_op(9'h1FF, 8'h3C, 0), 0,1,1, 9'h1FF, 0,0, 8'h00));
        tbl.push_back(mk(I, rd_op(9'h1FF, 0), 0,1,0, 9'h1FF, 0,0, 8'h00));
        tbl.push_back(mk(I, I, 0,0,0, 9'h000, 0,1, 8'h3C));
        // Contention: alternate A,B starting with A
        tbl.push_back(mk(rd_op(9'h010, 0), rd_op(9'h021, 0), 1,0,0, 9'h010, 0,0, 8'h00));
        tbl.push_back(mk(rd_op(9'h010, 0), rd_op(9'h021, 0), 0,1,0, 9'h021, 1,0, 8'hA5));
        tbl.push_back(mk(rd_op(9'h010, 0), rd_op(9'h021, 0), 1,0,0, 9'h010, 0,1, 8'h5A));
        tbl.push_back(mk(rd_op(9'h010, 0), rd_op(9'h021, 0), 0,1,0, 9'h021, 1,0, 8'hA5));
        tbl.push_back(mk(rd_op(9'h010, 0), rd_op(9'h021, 0), 1,0,0, 9'h010, 0,1, 8'h5A));
        tbl.push_back(mk(rd_op(9'h010, 0), rd_op(9'h021, 0), 0,1,0, 9'h021, 1,0, 8'hA5));
        tbl.push_back(mk(I, I, 0,0,0, 9'h000, 0,1, 8'h5A));
        // Locked burst by A while B waits
        tbl.push_back(mk(wr_op(9'h100, 8'h11, 1), wr_op(9'h050, 8'h77, 0), 1,0,1, 9'h100, 0,0, 8'h00));
        tbl.push_back(mk(wr_op(9'h101, 8'h12, 1), wr_op(9'h050, 8'h77, 0), 1,0,1, 9'h101, 0,0, 8'h00));
        tbl.push_back(mk(wr_op(9'h102, 8'h13, 1), wr_op(9'h050, 8'h77, 0), 1,0,1, 9'h102, 0,0, 8'h00));
        tbl.push_back(mk(wr_op(9'h103, 8'h14, 0), wr_op(9'h050, 8'h77, 0), 1,0,1, 9'h103, 0,0, 8'h00));
        tbl.push_back(mk(rd_op(9'h100, 0), wr_op(9'h050, 8'h77, 0), 0,1,1, 9'h050, 0,0, 8'h00));
        tbl.push_back(mk(rd_op(9'h100, 0), I, 1,0,0, 9'h100, 0,0, 8'h00));
        tbl.push_back(mk(I, I, 0,0,0, 9'h000, 1,0, 8'h11));
        // Abandoned lock
        tbl.push_back(mk(wr_op(9'h0AA, 8'h66, 1), I, 1,0,1, 9'h0AA, 0,0, 8'h00));
        tbl.push_back(mk(I, wr_op(9'h0BB, 8'h99, 0), 0,0,0, 9'h000, 0,0, 8'h00));
        tbl.push_back(mk(I, wr_op(9'h0BB, 8'h99, 0), 0,1,1, 9'h0BB, 0,0, 8'h00));
        tbl.push_back(mk(I, I, 0,0,0, 9'h000, 0,0, 8'h00));
        tbl.push_back(mk(wr_op(9'h0C0, 8'h5C, 0), I, 1,0,1, 9'h0C0, 0,0, 8'h00));

        foreach (tbl[i]) apply_row($sformatf("row%0d", i), tbl[i]);

        // Reset in the middle of a locked A burst with a read in flight
        apply_row("lock_beat1", mk(rd_op(9'h010, 1), I, 1,0,0, 9'h010, 0,0, 8'h00));
        drive(rd_op(9'h010, 1), rd_op(9'h021, 0));
        @(negedge clk);
        check_out("lock_beat2", 1, 0, 0, 9'h010, '0, 1, 0, 8'hA5);
        #5;
        rst_n = 1'b0;
        #1;
        check_out("rst_mid", 0, 0, 0, '0, '0, 0, 0, '0);
        drive(I, I);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #5;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        post.push_back(mk(I, rd_op(9'h021, 1), 0,1,0, 9'h021, 0,0, 8'h00));
        post.push_back(mk(I, I, 0,0,0, 9'h000, 0,1, 8'h5A));
        post.push_back(mk(rd_op(9'h010, 0), rd_op(9'h021, 0), 1,0,0, 9'h010, 0,0, 8'h00));
        post.push_back(mk(I, I, 0,0,0, 9'h000, 1,0, 8'hA5));
        foreach (post[i]) apply_row($sformatf("post%0d", i), post[i]);

        // Seed the random-phase address window with known contents
        for (int i = 0; i < 8; i++) begin
            logic [DW-1:0] d;
            d = 8'(i * 37 + 3);
            shadow[i] = d;
            apply_row($sformatf("seed%0d", i),
                      mk(wr_op(9'h180 + 9'(i), d, 0), I, 1,0,1, 9'h180 + 9'(i), 0,0, 8'h00));
        end

        // Randomized phase against the reference model
        m_owner = 0;
        m_prio  = 1'b1;
        begin
            req_t ca, cb, op;
            bit   took_a, took_b;
            took_a = 1'b1;
            took_b = 1'b1;
            ca = I;
            cb = I;
            for (int cyc = 0; cyc < 400; cyc++) begin
                int   win;
                int   nown;
                logic erva, ervb;
                logic [DW-1:0] erd;
                rd_t  e;
                if (took_a || !ca.r) ca = new_op();
                if (took_b || !cb.r) cb = new_op();
                drive(ca, cb);
                win  = pick(ca, cb);
                erva = 1'b0;
                ervb = 1'b0;
                erd  = '0;
                if (rdq.size() > 0) begin
                    e = rdq.pop_front();
                    erva = (e.side == 1);
                    ervb = (e.side == 2);
                    erd  = e.d;
                end
                op = (win == 1) ? ca : cb;
                @(negedge clk);
                check_out($sformatf("rnd%0d", cyc), win == 1, win == 2,
                          (win != 0) && op.w, (win != 0) ? op.a : '0,
                          (win != 0) ? op.d : '0, erva, ervb, erd);

                if (win != 0) begin
                    if (op.w) begin
                        shadow[op.a[2:0]] = op.d;
                    end else begin
                        e.side = win;
                        e.d    = shadow[op.a[2:0]];
                        rdq.push_back(e);
                    end
                end
                nown = m_owner;
                if (m_owner == 0) begin
                    if (win == 1 && ca.l) nown = 1;
                    else if (win == 2 && cb.l) nown = 2;
                end else if (m_owner == 1) begin
                    if (!ca.l) nown = 0;
                end else begin
                    if (!cb.l) nown = 0;
                end
                if (win != 0 && nown == 0) m_prio = (win == 1);
                m_owner = nown;
                took_a = (win == 1);
                took_b = (win == 2);
                @(posedge clk);
                #1;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
